// File: rtl/display_scan_scheduler_if.sv
// Message-memory write port for the scan scheduler: the host drives it (master),
// and the scheduler samples it on its clock (slave).
interface display_scan_scheduler_if #(
  parameter int unsigned MSG_LEN = 16
);
  logic                       msg_wr_en;
  logic [$clog2(MSG_LEN)-1:0] msg_wr_addr;
  logic [4:0]                 msg_wr_data;

  modport master (output msg_wr_en, output msg_wr_addr, output msg_wr_data);
  modport slave  (input  msg_wr_en, input  msg_wr_addr, input  msg_wr_data);
endinterface

// File: rtl/display_scan_scheduler.sv
// Time-multiplexed 7-segment scan controller with an optional scrolling message.
// Tick enables are derived from the single board clock; outputs decode registered state.
module display_scan_scheduler #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned SCAN_FREQ   = 1000,
  parameter int unsigned SCROLL_FREQ = 3,
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned MSG_LEN     = 16,
  parameter int unsigned HOLD_STEPS  = 4
) (
  input  logic                       clk_in,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       mode,
  display_scan_scheduler_if.slave    msg_wr,
  output logic [NUM_DIGITS-1:0]      digit_sel,
  output logic [4:0]                 symbol_out,
  output logic [$clog2(MSG_LEN)-1:0] scroll_pos,
  output logic                       frame_done
);
  localparam int unsigned SCAN_DIV   = CLK_FREQ / SCAN_FREQ;
  localparam int unsigned SCROLL_DIV = CLK_FREQ / SCROLL_FREQ;
  localparam int unsigned AW         = $clog2(MSG_LEN);
  localparam int unsigned DW         = $clog2(NUM_DIGITS);
  localparam int unsigned SCW        = $clog2(SCAN_DIV);
  localparam int unsigned RCW        = $clog2(SCROLL_DIV);
  localparam int unsigned HW         = $clog2(HOLD_STEPS + 1);
  localparam logic [4:0]  BLANK      = 5'h1F;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  state_e           state_q, state_d;
  logic [SCW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [RCW-1:0]   scroll_cnt_q, scroll_cnt_d;
  logic [DW-1:0]    d_q, d_d;
  logic [AW-1:0]    pos_q, pos_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             frame_q, frame_d;
  logic [4:0]       mem_q [MSG_LEN];

  logic             scan_tick, scroll_tick;
  logic [AW-1:0]    pos_inc;
  logic [HW-1:0]    hold_inc;
  logic [AW-1:0]    rd_addr;

  assign scan_tick   = (scan_cnt_q == SCW'(SCAN_DIV - 1));
  assign scroll_tick = (scroll_cnt_q == RCW'(SCROLL_DIV - 1));
  assign pos_inc     = pos_q + AW'(1);
  assign hold_inc    = hold_q + HW'(1);

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      scan_cnt_q   <= '0;
      scroll_cnt_q <= '0;
      d_q          <= '0;
      pos_q        <= '0;
      hold_q       <= '0;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_cnt_q   <= scan_cnt_d;
      scroll_cnt_q <= scroll_cnt_d;
      d_q          <= d_d;
      pos_q        <= pos_d;
      hold_q       <= hold_d;
      frame_q      <= frame_d;
    end
  end

  // Message memory is cleared only by reset; dropping enable keeps its contents.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < MSG_LEN; i++) mem_q[i] <= BLANK;
    end else if (msg_wr.msg_wr_en) begin
      mem_q[msg_wr.msg_wr_addr] <= msg_wr.msg_wr_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    scan_cnt_d   = scan_cnt_q;
    scroll_cnt_d = scroll_cnt_q;
    d_d          = d_q;
    pos_d        = pos_q;
    hold_d       = hold_q;
    frame_d      = 1'b0;

    if (!enable) begin
      state_d      = IDLE;
      scan_cnt_d   = '0;
      scroll_cnt_d = '0;
      d_d          = '0;
      pos_d        = '0;
      hold_d       = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = RUN;
          scan_cnt_d   = '0;
          scroll_cnt_d = '0;
          d_d          = '0;
        end
        RUN, HOLD: begin
          scan_cnt_d   = scan_tick   ? '0 : scan_cnt_q + SCW'(1);
          scroll_cnt_d = scroll_tick ? '0 : scroll_cnt_q + RCW'(1);
          if (scan_tick) begin
            d_d = (d_q == DW'(NUM_DIGITS - 1)) ? '0 : d_q + DW'(1);
          end
          // Scroll ticks advance the offset in RUN (scroll mode) or count the dwell in HOLD.
          if (scroll_tick) begin
            if (state_q == RUN) begin
              if (mode) begin
                pos_d = pos_inc;
                if (pos_inc == '0) begin
                  state_d = HOLD;
                  hold_d  = '0;
                  frame_d = 1'b1;
                end
              end
            end else begin
              hold_d = hold_inc;
              if (hold_inc == HW'(HOLD_STEPS)) state_d = RUN;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    digit_sel  = '1;
    symbol_out = BLANK;
    rd_addr    = mode ? (pos_q + AW'(d_q)) : AW'(d_q);
    if (state_q != IDLE) begin
      digit_sel  = ~(NUM_DIGITS'(1) << d_q);
      symbol_out = mem_q[rd_addr];
    end
  end

  assign scroll_pos = pos_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Directed bench for display_scan_scheduler: scan order, static/scroll symbols,
// HOLD dwell and frame period, enable drop, live write and mid-HOLD reset.
module tb_display_scan_scheduler;
  logic       clk_in = 1'b0;
  logic       reset_n, enable, mode;
  logic [7:0] digit_sel;
  logic [4:0] symbol_out;
  logic [3:0] scroll_pos;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;
  int run_t    = 0;

  display_scan_scheduler_if #(.MSG_LEN(16)) wr_if ();

  display_scan_scheduler #(
    .CLK_FREQ(1000), .SCAN_FREQ(250), .SCROLL_FREQ(50),
    .NUM_DIGITS(8), .MSG_LEN(16), .HOLD_STEPS(2)
  ) dut (
    .clk_in(clk_in), .reset_n(reset_n), .enable(enable), .mode(mode),
    .msg_wr(wr_if.slave),
    .digit_sel(digit_sel), .symbol_out(symbol_out),
    .scroll_pos(scroll_pos), .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
      run_t++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, run_t);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_sel"}, 32'(digit_sel), 32'hFF);
    chk({tag, "_sym"}, 32'(symbol_out), 32'h1F);
    chk({tag, "_pos"}, 32'(scroll_pos), 32'h0);
    chk({tag, "_fd"},  32'(frame_done), 32'h0);
  endtask

  logic [7:0] e_sel;
  logic [4:0] e_sym;
  int         e_pos, w, dd;

  initial begin
    reset_n = 1'b0; enable = 1'b0; mode = 1'b0;
    wr_if.msg_wr_en = 1'b0; wr_if.msg_wr_addr = '0; wr_if.msg_wr_data = '0;
    tick(2);
    chk_blank("reset");
    reset_n = 1'b1;
    tick(1);
    chk_blank("idle");

    // Static scan over a blank memory
    enable = 1'b1;
    tick(1);
    run_t = 0;
    for (int k = 0; k < 32; k++) begin
      e_sel = ~(8'd1 << (k / 4));
      chk("scan_sel", 32'(digit_sel), 32'(e_sel));
      chk("scan_sym_blank", 32'(symbol_out), 32'h1F);
      tick(1);
    end
    chk("scan_wrap_sel", 32'(digit_sel), 32'hFE);

    // Load msg[i] = i while scanning
    for (int i = 0; i < 16; i++) begin
      wr_if.msg_wr_en = 1'b1; wr_if.msg_wr_addr = 4'(i); wr_if.msg_wr_data = 5'(i);
      tick(1);
    end
    wr_if.msg_wr_en = 1'b0;
    while (run_t < 80) begin
      dd = (run_t / 4) % 8;
      chk("static_sym", 32'(symbol_out), 32'(dd));
      chk("static_pos", 32'(scroll_pos), 32'h0);
      tick(1);
    end
    chk("static_pos_frozen", 32'(scroll_pos), 32'h0);

    // Scroll mode: pos steps every 20 edges from t=100, wraps at 400, frame period 360
    mode = 1'b1;
    while (run_t < 1272) begin
      tick(1);
      dd = (run_t / 4) % 8;
      if (run_t < 400) e_pos = (run_t - 80) / 20;
      else begin
        w = (run_t - 400) % 360;
        e_pos = (w < 40) ? 0 : (w - 40) / 20;
      end
      e_sym = 5'((e_pos + dd) % 16);
      chk("scroll_pos", 32'(scroll_pos), 32'(e_pos));
      chk("scroll_sym", 32'(symbol_out), 32'(e_sym));
      chk("scroll_fd", 32'(frame_done), 32'((run_t >= 400) && ((run_t - 400) % 360 == 0)));
    end
    chk("pre_drop_pos", 32'(scroll_pos), 32'h5);
    chk("pre_drop_sel", 32'(digit_sel), 32'hBF);

    enable = 1'b0;
    tick(1);
    chk_blank("drop");

    // Re-enable in static mode: contents intact
    enable = 1'b1; mode = 1'b0;
    tick(1);
    run_t = 0;
    chk("reen_sel", 32'(digit_sel), 32'hFE);
    for (int k = 0; k < 32; k++) begin
      chk("reen_sym", 32'(symbol_out), 32'(k / 4));
      tick(1);
    end
    tick(8);
    chk("wr_pre_sel", 32'(digit_sel), 32'hFB);
    chk("wr_pre_sym", 32'(symbol_out), 32'h02);
    wr_if.msg_wr_en = 1'b1; wr_if.msg_wr_addr = 4'd2; wr_if.msg_wr_data = 5'h0A;
    tick(1);
    wr_if.msg_wr_en = 1'b0;
    chk("wr_live_sym", 32'(symbol_out), 32'h0A);

    // Scroll into HOLD, then reset mid-HOLD
    mode = 1'b1;
    tick(360 - run_t);
    chk("hold_fd", 32'(frame_done), 32'h1);
    chk("hold_pos", 32'(scroll_pos), 32'h0);
    tick(10);
    chk("hold_fd_low", 32'(frame_done), 32'h0);
    chk("hold_pos_mid", 32'(scroll_pos), 32'h0);
    chk("hold_sym", 32'(symbol_out), 32'h04);
    reset_n = 1'b0;
    tick(1);
    chk_blank("mid_hold_reset");
    reset_n = 1'b1;
    tick(1);
    run_t = 0;
    for (int k = 0; k < 8; k++) begin
      e_sel = ~(8'd1 << (k / 4));
      chk("post_rst_sel", 32'(digit_sel), 32'(e_sel));
      chk("post_rst_sym", 32'(symbol_out), 32'h1F);
      tick(1);
    end
    tick(20 - run_t);
    chk("post_rst_pos", 32'(scroll_pos), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
